arrow_lane_controller: RTL and testbench
========================================

// Module: arrow_lane_controller
// PURPOSE
//  Upstream position source for one arrow lane: drives x/y of the down-arrow sprite renderer.
//  Buffers spawn requests, moves the active arrow down once per frame during vertical blanking,
//  judges button presses against a hit window, and emits hit/miss/overflow pulses for scoring.
//  Only one arrow is live per lane; pending spawns wait in a small FIFO.
// PARAMETERS
//  LANE_X      400  fixed sprite x (left edge), driven on x_out
//  START_Y     0    y loaded when an arrow spawns
//  HIT_Y       560  centre of hit zone (sprite top edge)
//  WINDOW      24   half-width of hit zone, pixels
//  FRAME_LINE  720  vcount at which the per-frame tick fires (first blanking line)
//  QDEPTH      4    spawn FIFO depth (power of 2)
// PORTS
//  pixel_clk_in  in   1   pixel clock, all logic on rising edge
//  rst_in        in   1   synchronous, active-high reset
//  hcount_in     in   11  current pixel x from video timing
//  vcount_in     in   10  current pixel y from video timing
//  spawn_in      in   1   1-cycle spawn request
//  speed_in      in   4   pixels/frame for the spawned arrow, sampled with spawn_in
//  button_in     in   1   lane button, already synchronised/debounced
//  x_out         out  11  sprite x (constant LANE_X)
//  y_out         out  10  sprite y of live arrow
//  active_out    out  1   1 while an arrow is live (gate sprite output with this)
//  hit_out       out  1   1-cycle pulse: press inside window
//  miss_out      out  1   1-cycle pulse: arrow left window unpressed
//  overflow_out  out  1   1-cycle pulse: spawn dropped, FIFO full
// BEHAVIOUR
//  Reset: y_out=START_Y, active_out=0, all pulses 0, FIFO empty, state IDLE, button edge reg=0.
//  x_out = LANE_X at all times.
//  frame_tick = (hcount_in==0 && vcount_in==FRAME_LINE), 1 cycle/frame; y_out changes only on it.
//  press = button_in & ~button_q (rising edge, 1-cycle registered history).
//  FIFO: width 4, depth QDEPTH; push on spawn_in when not full; spawn_in while full -> drop,
//   overflow_out next cycle. Push and pop in same cycle both occur; pop of a full FIFO plus push
//   is not an overflow. Speed value 0 is stored as 1.
//  FSM:
//   IDLE: active_out=0. On frame_tick with FIFO non-empty: pop, y_out<=START_Y, spd<=head,
//     -> FALLING (active_out=1 next cycle). Pop only on frame_tick.
//   FALLING: in_win = (y_out >= HIT_Y-WINDOW) && (y_out <= HIT_Y+WINDOW), on current y_out.
//     press && in_win -> hit_out=1 next cycle, -> IDLE. Press outside window ignored.
//     frame_tick && !(press&&in_win): y_out<=y_out+spd; if new y > HIT_Y+WINDOW -> miss_out=1
//     next cycle, -> IDLE.
//     press and frame_tick in same cycle: judge with pre-increment y_out; hit wins over miss.
//  Leaving FALLING: active_out=0 and y_out holds its last value.
//  Pop takes effect only on a frame_tick in IDLE, so a new arrow appears at least one frame
//   after the previous one ends.
//  Widths: y add is 10-bit. Parameters must satisfy HIT_Y+WINDOW+15 < 1024, so no wrap.
//  hit_out and miss_out are mutually exclusive; at most one pulse per arrow.
//  rst_in mid-fall: arrow and FIFO discarded, no miss pulse.
//  Sprite stage adds BRAM latency; active_out is not delayed here.
// TESTING
//  reset, 3 frames no spawn -> active_out=0, y_out=0, no pulses
//  spawn speed=8, tick -> active, y=0; after 70 ticks y=560; press -> hit_out 1 cycle, IDLE
//  spawn speed=8, never press -> y reaches 592 (>584) -> miss_out once, active_out=0
//  5 spawns back-to-back with no tick -> 4 queued, overflow_out once; arrows served in order
//  press on same cycle as tick at y=584 -> hit (pre-increment), no miss
//  rst_in mid-fall at y=300 with 2 queued -> active 0, FIFO empty, no pulses

Source files
------------

// File: rtl/arrow_lane_controller.sv
// Position source for one down-arrow lane: queues spawns, steps the live arrow once per frame,
// and judges button presses against the hit window.
module arrow_lane_controller #(
   parameter int unsigned LANE_X     = 400,
   parameter int unsigned START_Y    = 0,
   parameter int unsigned HIT_Y      = 560,
   parameter int unsigned WINDOW     = 24,
   parameter int unsigned FRAME_LINE = 720,
   parameter int unsigned QDEPTH     = 4
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        spawn_in,
   input  logic [3:0]  speed_in,
   input  logic        button_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        active_out,
   output logic        hit_out,
   output logic        miss_out,
   output logic        overflow_out
);

   localparam int unsigned PW      = $clog2(QDEPTH);
   localparam logic [9:0]  WIN_LO  = 10'(HIT_Y - WINDOW);
   localparam logic [9:0]  WIN_HI  = 10'(HIT_Y + WINDOW);
   localparam logic [9:0]  Y_START = 10'(START_Y);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   typedef enum logic [0:0] {StIdle, StFalling} state_e;

   state_e      r_state;
   logic [3:0]  r_fifo [QDEPTH];
   logic [PW:0] r_wptr;
   logic [PW:0] r_rptr;
   logic [3:0]  r_spd;
   logic [9:0]  r_y;
   logic        r_active;
   logic        r_hit;
   logic        r_miss;
   logic        r_ovf;
   logic        r_button_q;

   logic        w_tick;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push;
   logic        w_ovf;
   logic [3:0]  w_spd_in;
   logic [3:0]  w_head;
   logic        w_press;
   logic        w_in_win;
   logic [9:0]  w_y_next;

   assign w_tick   = (hcount_in == 11'd0) && (vcount_in == 10'(FRAME_LINE));
   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) && (r_wptr[PW] != r_rptr[PW]);
   assign w_pop    = (r_state == StIdle) && w_tick && !w_empty;
   // A pop frees a slot in the same cycle, so a spawn into a full FIFO then still lands.
   assign w_push   = spawn_in && (!w_full || w_pop);
   assign w_ovf    = spawn_in && w_full && !w_pop;
   assign w_spd_in = (speed_in == 4'd0) ? 4'd1 : speed_in;
   assign w_head   = r_fifo[r_rptr[PW-1:0]];
   assign w_press  = button_in & ~r_button_q;
   assign w_in_win = (r_y >= WIN_LO) && (r_y <= WIN_HI);
   assign w_y_next = r_y + {6'd0, r_spd};

   always_ff @(posedge pixel_clk_in) begin
      if (w_push) begin
         r_fifo[r_wptr[PW-1:0]] <= w_spd_in;
      end
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         r_state    <= StIdle;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_spd      <= 4'd1;
         r_y        <= Y_START;
         r_active   <= 1'b0;
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_ovf      <= 1'b0;
         r_button_q <= 1'b0;
      end else begin
         r_button_q <= button_in;
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_ovf      <= w_ovf;
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         unique case (r_state)
            StIdle: begin
               r_active <= 1'b0;
               if (w_pop) begin
                  r_y      <= Y_START;
                  r_spd    <= w_head;
                  r_active <= 1'b1;
                  r_state  <= StFalling;
               end
            end
            StFalling: begin
               // Judged on the pre-increment position, so a hit beats a same-cycle miss.
               if (w_press && w_in_win) begin
                  r_hit    <= 1'b1;
                  r_active <= 1'b0;
                  r_state  <= StIdle;
               end else if (w_tick) begin
                  r_y <= w_y_next;
                  if (w_y_next > WIN_HI) begin
                     r_miss   <= 1'b1;
                     r_active <= 1'b0;
                     r_state  <= StIdle;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign x_out        = 11'(LANE_X);
   assign y_out        = r_y;
   assign active_out   = r_active;
   assign hit_out      = r_hit;
   assign miss_out     = r_miss;
   assign overflow_out = r_ovf;

endmodule

// File: tb/tb_arrow_lane_controller.sv
// Directed bench for arrow_lane_controller: frame ticks are forced by driving hcount/vcount.
module tb_arrow_lane_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] hcount = 11'd1;
   logic [9:0]  vcount = 10'd0;
   logic        spawn = 1'b0;
   logic [3:0]  speed = 4'd0;
   logic        button = 1'b0;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        active_out;
   logic        hit_out;
   logic        miss_out;
   logic        overflow_out;

   int n_cmp = 0;
   int n_err = 0;
   int n_hit = 0;
   int n_miss = 0;
   int n_ovf = 0;

   arrow_lane_controller dut (
      .pixel_clk_in (clk),
      .rst_in       (rst),
      .hcount_in    (hcount),
      .vcount_in    (vcount),
      .spawn_in     (spawn),
      .speed_in     (speed),
      .button_in    (button),
      .x_out        (x_out),
      .y_out        (y_out),
      .active_out   (active_out),
      .hit_out      (hit_out),
      .miss_out     (miss_out),
      .overflow_out (overflow_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (hit_out)      n_hit++;
      if (miss_out)     n_miss++;
      if (overflow_out) n_ovf++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      hcount = 11'd0;
      vcount = 10'd720;
      cyc();
      hcount = 11'd1;
      vcount = 10'd0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic spawn_one(input logic [3:0] s);
      spawn = 1'b1;
      speed = s;
      cyc();
      spawn = 1'b0;
   endtask

   // Serve one queued arrow to its miss; expected final y is the first multiple of s above 584.
   task automatic serve(input int s, input logic do_pop);
      int exp_y;
      if (do_pop) begin
         tick();
         check_val("serve_pop_active", 32'(active_out), 32'd1);
         check_val("serve_pop_y", 32'(y_out), 32'd0);
      end
      tick();
      check_val("serve_first_step", 32'(y_out), 32'(s));
      for (int i = 0; i < 1000 && active_out; i++) tick();
      exp_y = (584 / s + 1) * s;
      check_val("serve_ended", 32'(active_out), 32'd0);
      check_val("serve_final_y", 32'(y_out), 32'(exp_y));
   endtask

   initial begin
      int miss0;
      int hit0;
      logic [3:0] sp [5];
      sp[0] = 4'd0; sp[1] = 4'd2; sp[2] = 4'd3; sp[3] = 4'd4; sp[4] = 4'd9;

      // Reset and idle frames
      cyc();
      cyc();
      rst = 1'b0;
      check_val("rst_x", 32'(x_out), 32'd400);
      check_val("rst_y", 32'(y_out), 32'd0);
      check_val("rst_active", 32'(active_out), 32'd0);
      check_val("rst_pulses", {29'd0, hit_out, miss_out, overflow_out}, 32'd0);
      ticks(3);
      cyc();
      check_val("idle_active", 32'(active_out), 32'd0);
      check_val("idle_y", 32'(y_out), 32'd0);
      check_val("idle_pulses", 32'(n_hit + n_miss + n_ovf), 32'd0);

      // Hit at y=560
      spawn_one(4'd8);
      check_val("spawn_no_tick", 32'(active_out), 32'd0);
      hcount = 11'd0;
      vcount = 10'd719;
      cyc();
      hcount = 11'd1;
      vcount = 10'd0;
      check_val("wrong_line_no_pop", 32'(active_out), 32'd0);
      tick();
      check_val("pop_active", 32'(active_out), 32'd1);
      check_val("pop_y", 32'(y_out), 32'd0);
      button = 1'b1;
      cyc();
      button = 1'b0;
      check_val("early_press_ignored", 32'(active_out), 32'd1);
      check_val("early_press_no_hit", 32'(hit_out), 32'd0);
      ticks(70);
      check_val("y_after_70", 32'(y_out), 32'd560);
      hcount = 11'd5;
      vcount = 10'd720;
      cyc();
      hcount = 11'd1;
      vcount = 10'd0;
      check_val("hcount_nonzero_hold", 32'(y_out), 32'd560);
      button = 1'b1;
      cyc();
      check_val("hit_pulse", 32'(hit_out), 32'd1);
      check_val("hit_inactive", 32'(active_out), 32'd0);
      check_val("hit_y_hold", 32'(y_out), 32'd560);
      cyc();
      button = 1'b0;
      check_val("hit_one_cycle", 32'(hit_out), 32'd0);
      check_val("hit_count", 32'(n_hit), 32'd1);
      check_val("hit_no_miss", 32'(n_miss), 32'd0);

      // Miss at y=592
      spawn_one(4'd8);
      tick();
      ticks(73);
      check_val("pre_miss_y", 32'(y_out), 32'd584);
      check_val("pre_miss_active", 32'(active_out), 32'd1);
      tick();
      check_val("miss_pulse", 32'(miss_out), 32'd1);
      check_val("miss_inactive", 32'(active_out), 32'd0);
      check_val("miss_y", 32'(y_out), 32'd592);
      cyc();
      check_val("miss_one_cycle", 32'(miss_out), 32'd0);
      check_val("miss_count", 32'(n_miss), 32'd1);
      tick();
      check_val("empty_no_pop", 32'(active_out), 32'd0);
      check_val("empty_y_hold", 32'(y_out), 32'd592);

      // Overflow and in-order service
      spawn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         speed = sp[i];
         cyc();
         if (i == 3) check_val("full_no_ovf", 32'(overflow_out), 32'd0);
      end
      spawn = 1'b0;
      check_val("ovf_pulse", 32'(overflow_out), 32'd1);
      cyc();
      check_val("ovf_one_cycle", 32'(overflow_out), 32'd0);
      check_val("ovf_count", 32'(n_ovf), 32'd1);
      // Pop and push together on a full FIFO
      hcount = 11'd0;
      vcount = 10'd720;
      spawn = 1'b1;
      speed = 4'd6;
      cyc();
      hcount = 11'd1;
      vcount = 10'd0;
      spawn = 1'b0;
      check_val("poppush_no_ovf", 32'(overflow_out), 32'd0);
      check_val("poppush_active", 32'(active_out), 32'd1);
      serve(1, 1'b0);
      serve(2, 1'b1);
      serve(3, 1'b1);
      serve(4, 1'b1);
      serve(6, 1'b1);
      tick();
      cyc();
      check_val("queue_drained", 32'(active_out), 32'd0);
      check_val("queue_misses", 32'(n_miss), 32'd6);
      check_val("queue_ovf_total", 32'(n_ovf), 32'd1);

      // Press on the same cycle as a tick at y=584
      spawn_one(4'd8);
      tick();
      ticks(73);
      check_val("edge_pre_y", 32'(y_out), 32'd584);
      miss0 = n_miss;
      hcount = 11'd0;
      vcount = 10'd720;
      button = 1'b1;
      cyc();
      hcount = 11'd1;
      vcount = 10'd0;
      check_val("edge_hit", 32'(hit_out), 32'd1);
      check_val("edge_no_miss", 32'(miss_out), 32'd0);
      check_val("edge_y", 32'(y_out), 32'd584);
      cyc();
      button = 1'b0;
      check_val("edge_hit_count", 32'(n_hit), 32'd2);
      check_val("edge_miss_count", 32'(n_miss), 32'(miss0));

      // Reset mid-fall with two queued
      spawn_one(4'd10);
      spawn_one(4'd5);
      spawn_one(4'd5);
      tick();
      ticks(30);
      check_val("midfall_y", 32'(y_out), 32'd300);
      hit0 = n_hit;
      miss0 = n_miss;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_val("midrst_active", 32'(active_out), 32'd0);
      check_val("midrst_y", 32'(y_out), 32'd0);
      ticks(3);
      cyc();
      check_val("midrst_fifo_empty", 32'(active_out), 32'd0);
      check_val("midrst_no_hit", 32'(n_hit), 32'(hit0));
      check_val("midrst_no_miss", 32'(n_miss), 32'(miss0));
      check_val("midrst_no_ovf", 32'(n_ovf), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
